dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Bus-side data memory that answers the load/store strobe interface driven by the core's memory controller.
- Samples the active-low address strobe, word address, read/write select and write data.
- Inserts a programmable number of wait states, then performs a word read or write on an internal word array and returns a one-cycle ready pulse.
- Sits between the memory controller and on-chip SRAM.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; power of two, minimum 2.
- WAIT_CYCLES, 1, wait states between strobe sample and access commit; range 0..15.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_as_  input  1  address strobe, active low; a request is present while 0.
- rw  input  1  `READ / `WRITE encoding from define.v.
- addr  input  30  word address, `WORD_ADDR_BUS.
- wr_data  input  32  store data.
- rd_data  output  32  load data, registered.
- rdy  output  1  one-cycle completion pulse.
- busy  output  1  high from strobe acceptance until the rdy cycle inclusive.
- err  output  1  access-error pulse, coincident with rdy; exists only with the optional feature.

Behaviour:
- Reset: async assert forces state IDLE, rd_data=0, rdy=0, busy=0, err=0, wait counter=0.
  - Array contents are not reset.
  - Reset mid-operation abandons the request; a write not yet committed is never performed.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - mem_as_=0 at a rising edge accepts the request.
  - On acceptance, latch addr, rw and wr_data into request registers; set busy=1.
  - If WAIT_CYCLES=0, go directly to DONE with the commit performed on that same edge.
  - Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
  - mem_as_=1: stay in IDLE with rdy=0.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter=0, commit and go to DONE.
  - Bus inputs are ignored; only the latched request is used.
- Commit, one edge:
  - write: array[idx] <= latched wr_data; rd_data unchanged.
  - read: rd_data <= array[idx].
- DONE: rdy=1 and busy=1 for exactly one cycle, then IDLE.
  - mem_as_ is not sampled in DONE, so back-to-back requests need the strobe still low in the following IDLE cycle.
  - Minimum request spacing is WAIT_CYCLES+2 cycles.
- Latency: strobe sample edge to rdy high is WAIT_CYCLES+1 edges.
- rd_data holds the last read value until the next read commit; writes never alter it.
- idx = latched addr[log2(DEPTH)-1:0]; upper address bits are ignored, so addresses alias modulo DEPTH.
- Read of a just-written word returns the new value (commits are serialized).
- Array is a plain register/SRAM array with a single synchronous port; no byte enables (all stores are full-word).

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- Defined:
  - A latched addr >= DEPTH is out of range.
  - At commit: write suppressed, rd_data <= 0.
  - In DONE: err=1 together with rdy=1.
  - err is otherwise 0, and reset value is 0.
- Undefined: no err port and no range check; addresses alias per the idx rule.

Test Plan:
- Reset: assert rst mid-WAIT of a write to addr 5 with data 0xDEADBEEF → rd_data=0, rdy=0 and busy=0 immediately; a later read of addr 5 returns the pre-reset contents, not 0xDEADBEEF.
- Write/read (WAIT_CYCLES=1, DEPTH=1024):
  - Write 0x12345678 to addr 0x10 → rdy pulses 2 edges after the strobe sample; rd_data unchanged.
  - Read addr 0x10 → rdy pulse with rd_data=0x12345678, held afterward.
- Zero-wait (WAIT_CYCLES=0): read → rdy on the first edge after the sample; busy is high for exactly 1 cycle.
- Strobe held low continuously across 3 reads of addrs 1,2,3 (WAIT_CYCLES=2) → one rdy every 4 cycles, data in order, no extra accesses.
- Alias (feature off, DEPTH=1024): write 0xA5A5A5A5 to addr 0x400, read addr 0x000 → 0xA5A5A5A5.
- DMEM_ADDR_CHECK_EN on:
  - Write 0xFFFFFFFF to addr 1024 → err=1 with rdy.
  - Read addr 1024 → rd_data=0, err=1.
  - Read addr 0 → prior contents unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: strobe-driven 32-bit word memory for the core's memory controller.
// A request is sampled while mem_as_ is low. It waits WAIT_CYCLES cycles, then
// commits one read or write and returns a one-cycle rdy pulse.
// Optional macro: DMEM_ADDR_CHECK_EN adds the err port. Any address >= DEPTH
// then reads as zero, its write is dropped, and err pulses with rdy.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy,
  output logic        busy
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  // Bus read/write encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_rw_q, req_rw_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic              commit_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic              cur_rw_c;
  logic [DATA_W-1:0] cur_wdata_c;
  logic [IDX_W-1:0]  idx_c;
  logic              oor_c;
  logic              mem_we_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef DMEM_ADDR_CHECK_EN
  logic err_q, err_d;
`else
  logic unused_addr_hi_c;
`endif

  // Next-state logic: accept, count wait states, commit, then a one-cycle DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_rw_d    = req_rw_q;
    req_wdata_d = req_wdata_q;
    commit_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_as_) begin
          req_addr_d  = addr;
          req_rw_d    = rw;
          req_wdata_d = wr_data;
          if (WAIT_CYCLES == 0) begin
            state_d  = ST_DONE;
            commit_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit datapath. A zero-wait commit happens in IDLE, before the request
  // registers are loaded, so in that state it uses the live bus.
  always_comb begin
    cur_addr_c  = (state_q == ST_IDLE) ? addr    : req_addr_q;
    cur_rw_c    = (state_q == ST_IDLE) ? rw      : req_rw_q;
    cur_wdata_c = (state_q == ST_IDLE) ? wr_data : req_wdata_q;
    idx_c       = cur_addr_c[IDX_W-1:0];
    oor_c       = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
    oor_c       = ({2'b00, cur_addr_c} >= DEPTH);
`else
    unused_addr_hi_c = ^(cur_addr_c >> IDX_W);
`endif
    mem_we_c    = commit_c && (cur_rw_c == RW_WRITE) && !oor_c && !rst;
    rd_data_d   = rd_data_q;
    if (commit_c && (cur_rw_c == RW_READ)) begin
      rd_data_d = oor_c ? '0 : mem_q[idx_c];
    end
    rdy_d  = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
`ifdef DMEM_ADDR_CHECK_EN
    err_d  = commit_c && oor_c;
`endif
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      req_rw_q    <= RW_READ;
      req_wdata_q <= '0;
      rd_data_q   <= '0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_rw_q    <= req_rw_d;
      req_wdata_q <= req_wdata_d;
      rd_data_q   <= rd_data_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
`ifdef DMEM_ADDR_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Word array: single synchronous port. Its contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= cur_wdata_c;
    end
  end

  assign rd_data = rd_data_q;
  assign rdy     = rdy_q;
  assign busy    = busy_q;
`ifdef DMEM_ADDR_CHECK_EN
  assign err     = err_q;
`endif

endmodule
